// File: rtl/load_store_unit.sv
// load_store_unit
// Single-outstanding load/store sequencer between the core memory stage and a
// word-organised data memory (registered read port, synchronous write port,
// no byte enables). Byte addresses become word indices, sub-word loads are
// extracted and extended, and SB/SH are built as read-modify-write sequences.

module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;
  localparam logic [29:0] MEM_WORDS_IDX = 30'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LDX  = 3'd2,
    WR   = 3'd3,
    MRG  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        accept_s;
  logic        fault_s;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Illegal width code, misalignment, or word index beyond the memory.
  // Stores only support B/H/W; the unsigned codes are load-only.
  function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad_s;
    bad_s = 1'b0;
    case (f3)
      F3_B:    bad_s = 1'b0;
      F3_H:    bad_s = addr[0];
      F3_W:    bad_s = (addr[1:0] != 2'b00);
      F3_BU:   bad_s = we;
      F3_HU:   bad_s = we | addr[0];
      default: bad_s = 1'b1;
    endcase
    return bad_s | (addr[31:2] >= MEM_WORDS_IDX);
  endfunction

  // Select the addressed byte/half of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    byte_s = 8'(word >> {off, 3'b000});
    half_s = 16'(word >> {off[1], 4'b0000});
    case (f3)
      F3_B:    res_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   res_s = {24'h00_0000, byte_s};
      F3_H:    res_s = {{16{half_s[15]}}, half_s};
      F3_HU:   res_s = {16'h0000, half_s};
      F3_W:    res_s = word;
      default: res_s = 32'h0000_0000;
    endcase
    return res_s;
  endfunction

  // Replace the addressed byte (SB) or half (SH) of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [15:0] wdata);
    logic [4:0]  sh_s;
    logic [31:0] mask_s;
    logic [31:0] ins_s;
    case (f3)
      F3_B: begin
        sh_s   = {off, 3'b000};
        mask_s = 32'h0000_00FF << sh_s;
        ins_s  = {24'h00_0000, wdata[7:0]} << sh_s;
      end
      F3_H: begin
        sh_s   = {off[1], 4'b0000};
        mask_s = 32'h0000_FFFF << sh_s;
        ins_s  = {16'h0000, wdata} << sh_s;
      end
      default: begin
        sh_s   = 5'd0;
        mask_s = 32'h0000_0000;
        ins_s  = 32'h0000_0000;
      end
    endcase
    return (word & ~mask_s) | (ins_s & mask_s);
  endfunction

  // Ready is forced low while reset is asserted, independent of the clock.
  assign req_ready   = rst_n && (state_r == IDLE);
  assign accept_s    = req_valid && req_ready;
  assign fault_s     = req_fault(req_we, req_funct3, req_addr);
  assign mem_address = {2'b00, addr_q[31:2]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; errors and full-word stores skip the read.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (fault_s) begin
            state_next_s = RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_next_s = WR;
          end else begin
            state_next_s = RD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RD: begin
        if (we_q) begin
          state_next_s = MRG;
        end else begin
          state_next_s = LDX;
        end
      end
      LDX:     state_next_s = IDLE;
      WR:      state_next_s = IDLE;
      MRG:     state_next_s = IDLE;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Capture the request at the accepting edge; it is held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
    end else if (accept_s) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end else begin
      we_q     <= we_q;
      funct3_q <= funct3_q;
      addr_q   <= addr_q;
      wdata_q  <= wdata_q;
    end
  end

  // Memory strobes are pure state decodes so reset kills a pending write.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_data_in      = 32'h0000_0000;
    case (state_r)
      RD: begin
        mem_read_enable = 1'b1;
      end
      WR: begin
        mem_write_enable = 1'b1;
        mem_data_in      = wdata_q;
      end
      MRG: begin
        mem_write_enable = 1'b1;
        mem_data_in      = store_merge(mem_data_out, funct3_q, addr_q[1:0],
                                       wdata_q[15:0]);
      end
      default: begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_data_in      = 32'h0000_0000;
      end
    endcase
  end

  // Registered one-cycle response; data and error clear on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        LDX: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_extract(mem_data_out, funct3_q, addr_q[1:0]);
        end
        WR, MRG: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= 32'h0000_0000;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Scoreboard bench: each request pushes its expected {err, rdata}; a monitor
// pops and compares on every resp_valid. Scenario tasks check latency, memory
// strobe ordering and memory contents inline.

module tb_load_store_unit;

  localparam int MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [32:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_rdata       (resp_rdata),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  // data_mem model: registered read port, synchronous write port.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[4:0]] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= mem[mem_address[4:0]];
  end

  // Scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (mem_read_enable && mem_write_enable) begin
          errors++;
          $display("FAIL strobes: read and write enable both high at %0t", $time);
        end
        if (resp_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got err=%0b rdata=%h, want no response",
                     resp_err, resp_rdata);
          end else begin
            e = exp_q.pop_front();
            if ({resp_err, resp_rdata} !== e) begin
              errors++;
              $display("FAIL resp: got err=%0b rdata=%h, want err=%0b rdata=%h",
                       resp_err, resp_rdata, e[32], e[31:0]);
            end
          end
        end else begin
          checks++;
          if ((resp_err !== 1'b0) || (resp_rdata !== 32'h0)) begin
            errors++;
            $display("FAIL resp_idle: got err=%0b rdata=%h, want 0 0", resp_err, resp_rdata);
          end
        end
      end
    end
  endtask

  // Drive one request, wait for its response, report latency and strobe cycles.
  task automatic send(input vec_t v, output int lat, output int rd_k, output int wr_k);
    exp_q.push_back({v.err, v.rd});
    @(negedge clk);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = -1;
    rd_k = 0;
    wr_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read_enable && (rd_k == 0)) rd_k = k;
      if (mem_write_enable && (wr_k == 0)) wr_k = k;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_write_enable,
         mem_read_enable, mem_address, mem_data_in} !== 100'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b rv=%0b re=%0b rd=%h we=%0b ren=%0b addr=%h din=%h, want all 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_write_enable,
               mem_read_enable, mem_address, mem_data_in);
    end
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b, want 1", req_ready);
    end
  endtask

  task automatic test_word();
    int lat, rk, wk;
    send('{1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0}, lat, rk, wk);
    checks++;
    if ((lat != 2) || (rk != 0) || (wk != 1)) begin
      errors++;
      $display("FAIL sw_timing: got lat=%0d rd=%0d wr=%0d, want 2 0 1", lat, rk, wk);
    end
    checks++;
    if (mem[2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_mem: got %h, want deadbeef", mem[2]);
    end
    send('{1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF}, lat, rk, wk);
    checks++;
    if ((lat != 3) || (rk != 1) || (wk != 0)) begin
      errors++;
      $display("FAIL lw_timing: got lat=%0d rd=%0d wr=%0d, want 3 1 0", lat, rk, wk);
    end
    // Preload words used by later scenarios, including the last index.
    send('{1'b1, 3'b010, 32'h0C, 32'h80FF_7F01, 1'b0, 32'h0}, lat, rk, wk);
    send('{1'b1, 3'b010, 32'h04, 32'h1122_3344, 1'b0, 32'h0}, lat, rk, wk);
    send('{1'b1, 3'b010, 32'h00, 32'hCAFE_F00D, 1'b0, 32'h0}, lat, rk, wk);
    send('{1'b1, 3'b010, 32'h7C, 32'h1357_9BDF, 1'b0, 32'h0}, lat, rk, wk);
    send('{1'b0, 3'b010, 32'h7C, 32'h0, 1'b0, 32'h1357_9BDF}, lat, rk, wk);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL lw_last_word: got lat=%0d, want 3", lat);
    end
  endtask

  task automatic test_subword_load();
    vec_t v [8];
    int   lat, rk, wk;
    v[0] = '{1'b0, 3'b000, 32'h0E, 32'h0, 1'b0, 32'hFFFF_FFFF};
    v[1] = '{1'b0, 3'b100, 32'h0F, 32'h0, 1'b0, 32'h0000_0080};
    v[2] = '{1'b0, 3'b001, 32'h0E, 32'h0, 1'b0, 32'hFFFF_80FF};
    v[3] = '{1'b0, 3'b101, 32'h0C, 32'h0, 1'b0, 32'h0000_7F01};
    v[4] = '{1'b0, 3'b000, 32'h0D, 32'h0, 1'b0, 32'h0000_007F};
    v[5] = '{1'b0, 3'b100, 32'h0C, 32'h0, 1'b0, 32'h0000_0001};
    v[6] = '{1'b0, 3'b101, 32'h0E, 32'h0, 1'b0, 32'h0000_80FF};
    v[7] = '{1'b0, 3'b001, 32'h0C, 32'h0, 1'b0, 32'h0000_7F01};
    for (int i = 0; i < 8; i++) begin
      send(v[i], lat, rk, wk);
      checks++;
      if ((lat != 3) || (rk != 1) || (wk != 0)) begin
        errors++;
        $display("FAIL subload_timing[%0d]: got lat=%0d rd=%0d wr=%0d, want 3 1 0",
                 i, lat, rk, wk);
      end
    end
  endtask

  task automatic test_partial_store();
    vec_t        v [3];
    logic [31:0] w [3];
    int          lat, rk, wk;
    v[0] = '{1'b1, 3'b000, 32'h05, 32'hFFFF_FFAA, 1'b0, 32'h0};
    v[1] = '{1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 1'b0, 32'h0};
    v[2] = '{1'b1, 3'b000, 32'h04, 32'h0000_0F77, 1'b0, 32'h0};
    w[0] = 32'h1122_AA44;
    w[1] = 32'hBEEF_AA44;
    w[2] = 32'hBEEF_AA77;
    for (int i = 0; i < 3; i++) begin
      send(v[i], lat, rk, wk);
      checks++;
      if ((lat != 3) || (rk != 1) || (wk != 2)) begin
        errors++;
        $display("FAIL rmw_timing[%0d]: got lat=%0d rd=%0d wr=%0d, want 3 1 2",
                 i, lat, rk, wk);
      end
      checks++;
      if (mem[1] !== w[i]) begin
        errors++;
        $display("FAIL rmw_mem[%0d]: got %h, want %h", i, mem[1], w[i]);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v [9];
    int   lat, rk, wk;
    v[0] = '{1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 32'h0};
    v[1] = '{1'b1, 3'b001, 32'h01, 32'hFFFF_FFFF, 1'b1, 32'h0};
    v[2] = '{1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0};
    v[3] = '{1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 32'h0};
    v[4] = '{1'b1, 3'b100, 32'h00, 32'hFFFF_FFFF, 1'b1, 32'h0};
    v[5] = '{1'b0, 3'b110, 32'h00, 32'h0, 1'b1, 32'h0};
    v[6] = '{1'b0, 3'b101, 32'h03, 32'h0, 1'b1, 32'h0};
    v[7] = '{1'b1, 3'b010, 32'h7E, 32'hFFFF_FFFF, 1'b1, 32'h0};
    v[8] = '{1'b1, 3'b000, 32'h80, 32'hFFFF_FFFF, 1'b1, 32'h0};
    for (int i = 0; i < 9; i++) begin
      send(v[i], lat, rk, wk);
      checks++;
      if ((lat != 2) || (rk != 0) || (wk != 0)) begin
        errors++;
        $display("FAIL err_timing[%0d]: got lat=%0d rd=%0d wr=%0d, want 2 0 0",
                 i, lat, rk, wk);
      end
    end
    checks++;
    if ((mem[0] !== 32'hCAFE_F00D) || (mem[1] !== 32'hBEEF_AA77) ||
        (mem[31] !== 32'h1357_9BDF)) begin
      errors++;
      $display("FAIL err_mem: got %h %h %h, want cafef00d beefaa77 13579bdf",
               mem[0], mem[1], mem[31]);
    end
  endtask

  task automatic test_reset_in_merge();
    int lat, rk, wk;
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h05;
    req_wdata  = 32'h0000_0011;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL mrg_reached: got we=%0b, want 1", mem_write_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_write_enable,
         mem_read_enable, mem_address, mem_data_in} !== 100'h0) begin
      errors++;
      $display("FAIL mrg_reset_outputs: got ready=%0b rv=%0b we=%0b ren=%0b addr=%h din=%h, want all 0",
               req_ready, resp_valid, mem_write_enable, mem_read_enable,
               mem_address, mem_data_in);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ((mem[1] !== 32'hBEEF_AA77) || (req_ready !== 1'b1)) begin
      errors++;
      $display("FAIL mrg_reset_state: got mem=%h ready=%0b, want beefaa77 1",
               mem[1], req_ready);
    end
    send('{1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'hBEEF_AA77}, lat, rk, wk);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL mrg_reset_reload: got lat=%0d, want 3", lat);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [3];
    int   acc [3];
    int   tick;
    logic rdy;
    v[0] = '{1'b1, 3'b010, 32'h10, 32'hA5A5_A5A5, 1'b0, 32'h0};
    v[1] = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hA5A5_A5A5};
    v[2] = '{1'b1, 3'b000, 32'h11, 32'h0000_003C, 1'b0, 32'h0};
    tick = 0;
    for (int i = 0; i < 3; i++) begin
      acc[i] = -100;
      @(negedge clk);
      exp_q.push_back({v[i].err, v[i].rd});
      req_we     = v[i].we;
      req_funct3 = v[i].f3;
      req_addr   = v[i].addr;
      req_wdata  = v[i].wd;
      req_valid  = 1'b1;
      for (int k = 0; k < 8; k++) begin
        #1 rdy = req_ready;
        @(posedge clk);
        tick++;
        if (rdy) begin
          acc[i] = tick;
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (((acc[1] - acc[0]) != 2) || ((acc[2] - acc[1]) != 3)) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d %0d, want 2 3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (mem[4] !== 32'hA5A5_3CA5) begin
      errors++;
      $display("FAIL b2b_mem: got %h, want a5a53ca5", mem[4]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_word();
    test_subword_load();
    test_partial_store();
    test_errors();
    test_reset_in_merge();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the RISC-V core's memory stage and the word-organised `data_mem` (32×32-bit, one registered read port, one synchronous write port, no byte enables). It accepts one load/store request at a time and converts byte addresses to word indices. It extracts and sign- or zero-extends sub-word loads. It builds SB/SH stores as read-modify-write sequences.

## Interface
- `MEM_WORDS`, 32: number of words in `data_mem`; any word index ≥ `MEM_WORDS` is an access fault.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE with `rst_n` high; a request is accepted at a rising edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: qualifies `resp_valid`; misaligned, illegal funct3 or out-of-range access.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `mem_write_enable` out 1: to `data_mem.write_enable`.
- `mem_read_enable` out 1: to `data_mem.read_enable`.
- `mem_address` out 32: word index `{2'b00, addr_q[31:2]}`.
- `mem_data_in` out 32: write data.
- `mem_data_out` in 32: `data_mem` registered read data, valid the cycle after a read-enable edge.

## Operation
- **Request capture**
  - The accepting edge registers `we`, `funct3`, `addr` and `wdata` into `_q` registers.
  - The request is decoded from these registers.
- **Error check at acceptance**
  - Error conditions:
    - illegal funct3: 011, 110 or 111; for stores, anything above 010;
    - H/HU with `addr[0]=1`;
    - W with `addr[1:0]≠0`;
    - `addr[31:2] ≥ MEM_WORDS`.
  - On error: go to RESP with `resp_err=1` and issue no memory access.
- **States**
  - IDLE: `req_ready=1`.
    - Accepted error → RESP.
    - Accepted SW → WR.
    - Accepted load, SB or SH → RD.
  - RD: `mem_read_enable=1`.
    - Load → LDX.
    - Partial store → MRG.
  - LDX: extract from `mem_data_out` at offset `addr_q[1:0]`.
    - LB/LBU: byte `[8*off+7:8*off]`, sign- or zero-extended.
    - LH/LHU: half `[16*addr_q[1]+15 : 16*addr_q[1]]`, sign- or zero-extended.
    - LW: the full word.
    - Registers `resp_rdata`, pulses `resp_valid` → IDLE.
  - WR: `mem_write_enable=1`, `mem_data_in=wdata_q` → IDLE with `resp_valid` pulse.
  - MRG: `mem_write_enable=1`.
    - `mem_data_in` = `mem_data_out` with the addressed byte replaced by `wdata_q[7:0]` (SB) or the addressed half replaced by `wdata_q[15:0]` (SH).
    - → IDLE with `resp_valid` pulse.
  - RESP: error response cycle; registers `resp_valid=1`, `resp_err=1` → IDLE.
- **Memory-side rules**
  - `mem_read_enable` and `mem_write_enable` are never high in the same cycle.
  - Both enables are pure decodes of state, so they are 0 in every other state.
  - `mem_address` holds the captured index from acceptance until the next acceptance.
- **Reset**
  - Asynchronous; every output becomes 0, including `req_ready` while `rst_n` is low.
  - FSM returns to IDLE; the in-flight request is discarded.
  - Assertion during WR or MRG deasserts `mem_write_enable` before the next edge, so no write occurs.
  - `data_mem` contents are unaffected.

## Timing
Edges are counted from the accepting edge E0.
- **Valid load:** read edge E1; `resp_valid`/`resp_rdata` registered at E2, high for the E2–E3 cycle.
- **SW:** write commits at E1; `resp_valid` high E1–E2.
- **SB/SH:** read at E1, merged write commits at E2; `resp_valid` high E2–E3.
- **Error:** `resp_valid`, `resp_err` high E1–E2.
- **Back-to-back:** `req_ready` is high in the same cycle `resp_valid` is high, so back-to-back requests are accepted with no bubble.
- **Pulse width:** `resp_valid` is exactly one cycle; `resp_err` and `resp_rdata` are cleared to 0 in the following IDLE cycle.
- **Throughput:** one request per 2 cycles (loads, partial stores), 1 cycle (SW, errors) plus the acceptance cycle.

## Test plan
- SW `addr=0x08`, `wdata=0xDEADBEEF`, then LW `0x08` → write at E1 to word 2; load `resp_rdata=0xDEADBEEF` at E2, `resp_err=0`.
- Word 3 = `0x80FF7F01`:
  - LB `0x0E` → `0xFFFFFFFF`.
  - LBU `0x0F` → `0x00000080`.
  - LH `0x0E` → `0xFFFF80FF`.
  - LHU `0x0C` → `0x00007F01`.
- Word 1 = `0x11223344`:
  - SB `0x05`, wdata `0xAA` → word 1 = `0x1122AA44`.
  - SH `0x06`, wdata `0xBEEF` → `0xBEEFAA44`.
  - Check: read then write, never both enables high in one cycle.
- Error cases:
  - LW `0x02`, SH `0x01`, funct3=011 and LW `0x80` (index 32) each → `resp_err=1` at E1, `rdata=0`.
  - No enable ever asserted; memory unchanged.
- `rst_n` pulsed low during MRG of an SB → `mem_write_enable` drops immediately, target word keeps its old value, all outputs 0, FSM IDLE; a following LW returns the old word.
- Back-to-back SW, LW, SB with `req_valid` held high → each accepted in its `resp_valid` cycle, correct data, no bubbles.
